// File: rtl/reg_sched_pkg.sv
// Shared constants, FSM encoding and write-request type for the register
// write scheduler and its scoreboard.
package reg_sched_pkg;

    localparam int REG_ADDR_W           = 5;
    localparam int DATA_W               = 32;
    localparam int NUM_REGS             = 1 << REG_ADDR_W;
    localparam int CNT_W                = 3;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    function automatic wr_req_t make_req(input logic                  valid,
                                         input logic [REG_ADDR_W-1:0] rd,
                                         input logic [DATA_W-1:0]     data);
        wr_req_t r;
        r.valid = valid;
        r.rd    = rd;
        r.data  = data;
        return r;
    endfunction

endpackage

// File: rtl/reg_write_scheduler_if.sv
// Pipeline-facing bundle of the scheduler: writeback, mul/div result,
// issue tracking, decode operand check and register-file write port.
interface reg_write_scheduler_if;
    import reg_sched_pkg::*;

    logic                  wbValidIn;
    logic [REG_ADDR_W-1:0] wbRdIn;
    logic [DATA_W-1:0]     wbDataIn;

    logic                  mdValidIn;
    logic [REG_ADDR_W-1:0] mdRdIn;
    logic [DATA_W-1:0]     mdDataIn;
    logic                  mdReadyOut;

    logic                  issueIn;
    logic [REG_ADDR_W-1:0] issueRdIn;

    logic [REG_ADDR_W-1:0] rs1In;
    logic [REG_ADDR_W-1:0] rs2In;
    logic [REG_ADDR_W-1:0] rdIn;
    logic                  hazardOut;
    logic                  stallOut;

    logic                  regWriteOut;
    logic [REG_ADDR_W-1:0] regRdOut;
    logic [DATA_W-1:0]     regDataOut;
    logic [NUM_REGS-1:0]   busyOut;

    modport master (
        output wbValidIn, wbRdIn, wbDataIn,
        output mdValidIn, mdRdIn, mdDataIn,
        output issueIn, issueRdIn,
        output rs1In, rs2In, rdIn,
        input  mdReadyOut, hazardOut, stallOut,
        input  regWriteOut, regRdOut, regDataOut, busyOut
    );

    modport slave (
        input  wbValidIn, wbRdIn, wbDataIn,
        input  mdValidIn, mdRdIn, mdDataIn,
        input  issueIn, issueRdIn,
        input  rs1In, rs2In, rdIn,
        output mdReadyOut, hazardOut, stallOut,
        output regWriteOut, regRdOut, regDataOut, busyOut
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy vector for registers with an outstanding multi-cycle result.
// r0 is never busy; a set beats a clear to the same register.
module reg_scoreboard
    import reg_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  hazard
);

    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_rd] = 1'b0;
        if (set_en) busy_next[set_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    // During reset the query reflects the scoreboard as it is about to become.
    assign hazard = !rst && (busy[rs1] | busy[rs2] | busy[rd]);

endmodule

// File: rtl/reg_write_scheduler.sv
// Arbitrates the single register-file write port between pipeline writeback
// and the mul/div unit, with anti-starvation via a one-entry skid buffer.
module reg_write_scheduler
    import reg_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                 clkIn,
    input  logic                 resetIn,
    reg_write_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    sched_state_e          state, state_next;
    logic [CNT_W-1:0]      starve_cnt;
    logic                  starve_hit;
    logic                  md_ready;
    logic                  md_accept;
    logic                  skid_capture;
    logic                  stall;
    wr_req_t               wb_req, md_req, skid, grant;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] reg_rd;
    logic [DATA_W-1:0]     reg_data;
    logic                  hazard;
    logic [NUM_REGS-1:0]   busy;

    assign wb_req     = make_req(bus.wbValidIn, bus.wbRdIn, bus.wbDataIn);
    assign md_req     = make_req(bus.mdValidIn, bus.mdRdIn, bus.mdDataIn);
    assign starve_hit = (starve_cnt == LIMIT);
    assign md_accept  = md_ready && md_req.valid;

    always_ff @(posedge clkIn) begin
        if (resetIn) state <= NORMAL;
        else         state <= state_next;
    end

    // wbValidIn is ignored in DRAIN: the pipeline is stalled and any request
    // seen there is a protocol violation.
    always_comb begin
        state_next   = state;
        md_ready     = 1'b0;
        stall        = 1'b0;
        skid_capture = 1'b0;
        grant        = '0;
        if (!resetIn) begin
            unique case (state)
                NORMAL: begin
                    md_ready = !wb_req.valid || starve_hit;
                    if (md_ready && md_req.valid) begin
                        grant = md_req;
                        if (wb_req.valid) begin
                            skid_capture = 1'b1;
                            state_next   = DRAIN;
                        end
                    end else begin
                        grant = wb_req;
                    end
                end
                DRAIN: begin
                    stall      = 1'b1;
                    grant      = skid;
                    state_next = NORMAL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            starve_cnt <= '0;
            skid       <= '0;
            reg_write  <= 1'b0;
            reg_rd     <= '0;
            reg_data   <= '0;
        end else begin
            if (!md_req.valid || md_accept)  starve_cnt <= '0;
            else if (starve_cnt != '1)       starve_cnt <= starve_cnt + 1'b1;

            if (skid_capture)        skid       <= wb_req;
            else if (state == DRAIN) skid.valid <= 1'b0;

            // Writes to r0 are dropped here; handshakes upstream still complete.
            reg_write <= grant.valid && (grant.rd != '0);
            if (grant.valid && (grant.rd != '0)) begin
                reg_rd   <= grant.rd;
                reg_data <= grant.data;
            end
        end
    end

    reg_scoreboard u_scoreboard (
        .clk    (clkIn),
        .rst    (resetIn),
        .set_en (bus.issueIn),
        .set_rd (bus.issueRdIn),
        .clr_en (md_accept),
        .clr_rd (bus.mdRdIn),
        .rs1    (bus.rs1In),
        .rs2    (bus.rs2In),
        .rd     (bus.rdIn),
        .busy   (busy),
        .hazard (hazard)
    );

    assign bus.mdReadyOut  = md_ready;
    assign bus.stallOut    = stall;
    assign bus.hazardOut   = hazard;
    assign bus.busyOut     = busy;
    assign bus.regWriteOut = reg_write;
    assign bus.regRdOut    = reg_rd;
    assign bus.regDataOut  = reg_data;

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed scenarios plus randomized traffic against a behavioural model of
// the write port arbitration, starvation rule and busy scoreboard.
module tb_reg_write_scheduler;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_write_scheduler_if bus();

    reg_write_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clkIn   (clk),
        .resetIn (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    bit mdl_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.wbValidIn = v;
        bus.wbRdIn    = r;
        bus.wbDataIn  = d;
    endtask

    task automatic set_md(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.mdValidIn = v;
        bus.mdRdIn    = r;
        bus.mdDataIn  = d;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] r);
        bus.issueIn   = v;
        bus.issueRdIn = r;
    endtask

    // Behavioural model: who owns the write port this cycle, what lands on the
    // register file next cycle, and which registers are still awaiting results.
    logic [31:0] m_busy  = '0;
    int          m_cnt   = 0;
    bit          m_drain = 1'b0;
    logic [4:0]  s_rd    = '0;
    logic [31:0] s_data  = '0;
    bit          m_we    = 1'b0;
    logic [4:0]  m_rd    = '0;
    logic [31:0] m_data  = '0;

    always @(negedge clk) begin
        bit          rdy, acc, wr;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        if (mdl_on) begin
            rdy = !rst && !m_drain && (!bus.wbValidIn || m_cnt == LIMIT);
            chk("md_ready", 32'(bus.mdReadyOut), 32'(rdy));
            chk("stall", 32'(bus.stallOut), 32'(!rst && m_drain));
            chk("hazard", 32'(bus.hazardOut),
                32'(!rst && (m_busy[bus.rs1In] | m_busy[bus.rs2In] | m_busy[bus.rdIn])));
            chk("busy", bus.busyOut, m_busy);
            chk("reg_write", 32'(bus.regWriteOut), 32'(m_we));
            if (m_we) begin
                chk("reg_rd", 32'(bus.regRdOut), 32'(m_rd));
                chk("reg_data", bus.regDataOut, m_data);
            end
            if (rst) begin
                m_busy = '0; m_cnt = 0; m_drain = 1'b0;
                m_we = 1'b0; m_rd = '0; m_data = '0;
            end else begin
                acc  = rdy && bus.mdValidIn;
                wr   = 1'b0;
                wrd  = '0;
                wdat = '0;
                if (m_drain) begin
                    wr = 1'b1; wrd = s_rd; wdat = s_data;
                    m_drain = 1'b0;
                end else if (acc) begin
                    wr = 1'b1; wrd = bus.mdRdIn; wdat = bus.mdDataIn;
                    if (bus.wbValidIn) begin
                        s_rd = bus.wbRdIn; s_data = bus.wbDataIn;
                        m_drain = 1'b1;
                    end
                end else if (bus.wbValidIn) begin
                    wr = 1'b1; wrd = bus.wbRdIn; wdat = bus.wbDataIn;
                end
                m_we = wr && (wrd != 0);
                if (m_we) begin
                    m_rd = wrd; m_data = wdat;
                end
                m_cnt = (bus.mdValidIn && !acc) ? m_cnt + 1 : 0;
                if (acc) m_busy[bus.mdRdIn] = 1'b0;
                if (bus.issueIn && bus.issueRdIn != 0) m_busy[bus.issueRdIn] = 1'b1;
            end
        end
    end

    initial begin
        bit md_pend;
        set_wb(0, 0, 0);
        set_md(0, 0, 0);
        set_issue(0, 0);
        bus.rs1In = '0; bus.rs2In = '0; bus.rdIn = '0;

        // Reset state
        rst = 1'b1;
        cyc();
        mdl_on = 1'b1;
        #1;
        chk("rst_md_ready", 32'(bus.mdReadyOut), 32'd0);
        chk("rst_stall", 32'(bus.stallOut), 32'd0);
        cyc();
        chk("rst_reg_write", 32'(bus.regWriteOut), 32'd0);
        chk("rst_busy", bus.busyOut, 32'd0);
        rst = 1'b0;

        // Plain writeback
        set_wb(1, 5, 32'h11);
        cyc();
        chk("wb_we", 32'(bus.regWriteOut), 32'd1);
        chk("wb_rd", 32'(bus.regRdOut), 32'd5);
        chk("wb_data", bus.regDataOut, 32'h11);
        set_wb(0, 0, 0);

        // Issue r7, hazard, then md result clears it
        set_issue(1, 7);
        cyc();
        set_issue(0, 0);
        chk("busy7_set", 32'(bus.busyOut[7]), 32'd1);
        bus.rs1In = 5'd7;
        #1 chk("hazard7", 32'(bus.hazardOut), 32'd1);
        set_md(1, 7, 32'hABCD);
        #1 chk("md7_ready", 32'(bus.mdReadyOut), 32'd1);
        cyc();
        set_md(0, 0, 0);
        chk("busy7_clr", 32'(bus.busyOut[7]), 32'd0);
        chk("md7_we", 32'(bus.regWriteOut), 32'd1);
        chk("md7_rd", 32'(bus.regRdOut), 32'd7);
        chk("md7_data", bus.regDataOut, 32'hABCD);
        #1 chk("hazard7_gone", 32'(bus.hazardOut), 32'd0);
        bus.rs1In = '0;

        // Starvation: md forced through on cycle LIMIT+1, wb goes via skid
        set_md(1, 3, 32'h33);
        for (int k = 1; k <= LIMIT; k++) begin
            set_wb(1, 10, 32'h100 + k);
            #1 chk("starve_wait_ready", 32'(bus.mdReadyOut), 32'd0);
            cyc();
            chk("starve_wb_rd", 32'(bus.regRdOut), 32'd10);
            chk("starve_wb_data", bus.regDataOut, 32'h100 + k);
        end
        set_wb(1, 10, 32'h1FF);
        #1 chk("starve_grant", 32'(bus.mdReadyOut), 32'd1);
        cyc();
        set_md(0, 0, 0);
        set_wb(0, 0, 0);
        #1 chk("drain_stall", 32'(bus.stallOut), 32'd1);
        chk("starve_md_rd", 32'(bus.regRdOut), 32'd3);
        chk("starve_md_data", bus.regDataOut, 32'h33);
        cyc();
        chk("skid_we", 32'(bus.regWriteOut), 32'd1);
        chk("skid_rd", 32'(bus.regRdOut), 32'd10);
        chk("skid_data", bus.regDataOut, 32'h1FF);
        chk("drain_done", 32'(bus.stallOut), 32'd0);

        // Set and clear of r9 in the same cycle: set wins
        set_issue(1, 9);
        set_md(1, 9, 32'h99);
        cyc();
        set_issue(0, 0);
        set_md(0, 0, 0);
        chk("busy9_set_wins", 32'(bus.busyOut[9]), 32'd1);
        chk("md9_rd", 32'(bus.regRdOut), 32'd9);

        // r0 writes suppressed, md handshake still completes
        set_wb(1, 0, 32'hDEAD);
        cyc();
        set_wb(0, 0, 0);
        chk("wb_r0_we", 32'(bus.regWriteOut), 32'd0);
        set_md(1, 0, 32'hBEEF);
        #1 chk("md_r0_ready", 32'(bus.mdReadyOut), 32'd1);
        cyc();
        set_md(0, 0, 0);
        chk("md_r0_we", 32'(bus.regWriteOut), 32'd0);
        chk("md_r0_busy", bus.busyOut, 32'h0000_0200);

        // Reset while draining with busy bits set
        set_issue(1, 4);
        cyc();
        set_issue(0, 0);
        set_md(1, 12, 32'hC0C0);
        set_wb(1, 11, 32'hB0B0);
        for (int k = 0; k <= LIMIT; k++) cyc();
        #1 chk("rd_drain_stall", 32'(bus.stallOut), 32'd1);
        chk("rd_drain_busy", bus.busyOut, 32'h0000_0210);
        rst = 1'b1;
        set_md(0, 0, 0);
        set_wb(0, 0, 0);
        bus.rs1In = 5'd4;
        #1 chk("rd_rst_stall", 32'(bus.stallOut), 32'd0);
        chk("rd_rst_ready", 32'(bus.mdReadyOut), 32'd0);
        chk("rd_rst_hazard", 32'(bus.hazardOut), 32'd0);
        cyc();
        rst = 1'b0;
        chk("rd_post_we", 32'(bus.regWriteOut), 32'd0);
        chk("rd_post_rd", 32'(bus.regRdOut), 32'd0);
        chk("rd_post_data", bus.regDataOut, 32'd0);
        chk("rd_post_busy", bus.busyOut, 32'd0);
        cyc();
        chk("rd_no_skid", 32'(bus.regWriteOut), 32'd0);
        bus.rs1In = '0;

        // Randomized traffic; the md unit holds a result until it is taken
        md_pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (rst || (bus.mdValidIn && bus.mdReadyOut)) md_pend = 1'b0;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 199) == 0);
            set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
            if (!md_pend && $urandom_range(0, 2) == 0) begin
                md_pend = 1'b1;
                bus.mdRdIn   = 5'($urandom_range(0, 15));
                bus.mdDataIn = $urandom;
            end else if (md_pend && $urandom_range(0, 19) == 0) begin
                md_pend = 1'b0;
            end
            bus.mdValidIn = md_pend;
            set_issue(1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)));
            bus.rs1In = 5'($urandom_range(0, 15));
            bus.rs2In = 5'($urandom_range(0, 15));
            bus.rdIn  = 5'($urandom_range(0, 15));
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
